// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the restoring divider:
//   - DEFAULT_WIDTH : default operand/result width (RV64 datapath)
//   - div_state_e   : controller state encoding (IDLE, CALC, FIX)
//   - cnt_width()   : width of the step counter, $clog2(width+1)
// -----------------------------------------------------------------------------
package divider_pkg;

    localparam int DEFAULT_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    // Step counter must be able to hold the value WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int STEP_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   rem      in  WIDTH  partial remainder (always < divisor)
//   quo      in  WIDTH  dividend bits still to shift in / quotient bits so far
//   divisor  in  WIDTH  divisor magnitude
//   rem_next out WIDTH  partial remainder after this step
//   quo_next out WIDTH  quo shifted left with the new quotient bit in the LSB
// -----------------------------------------------------------------------------
module div_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] rem_shifted;
    logic [WIDTH:0] trial;

    // Shift {rem,quo} left by one: the dividend MSB moves into the remainder.
    assign rem_shifted = {rem, quo[WIDTH-1]};

    // Because rem < divisor, rem_shifted - divisor lies in [-divisor, divisor-1],
    // so WIDTH+1 bits are enough and bit WIDTH is a true sign bit.
    assign trial = rem_shifted - {1'b0, divisor};

    // Negative trial: restore (keep the shifted remainder, whose MSB is then 0).
    assign rem_next = trial[WIDTH] ? rem_shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/restoring_divider.sv
// -----------------------------------------------------------------------------
// restoring_divider
// Multi-cycle DIV/DIVU/REM/REMU unit, one restoring step per clock, with
// RISC-V results for divide-by-zero and signed overflow.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   start        in   request, sampled only while busy=0
//   is_signed    in   1 = DIV/REM, 0 = DIVU/REMU
//   dividend     in   WIDTH numerator (sampled with start)
//   divisor      in   WIDTH denominator (sampled with start)
//   busy         out  operation in progress
//   done         out  one-cycle pulse, results valid
//   quotient     out  WIDTH, held until next done
//   remainder    out  WIDTH, held until next done
//   div_by_zero  out  qualified by done
//
// Build option: DIVIDER_EARLY_OUT_EN - when defined, divide-by-zero and
// signed overflow skip the CALC steps and complete with latency 1. Results
// are identical either way.
// -----------------------------------------------------------------------------
module restoring_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CNT_W     = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_reg,     state_next;
    logic [CNT_W-1:0] cnt_reg,       cnt_next;
    logic [WIDTH-1:0] rem_reg,       rem_next;
    logic [WIDTH-1:0] quo_reg,       quo_next;
    logic [WIDTH-1:0] dvs_reg,       dvs_next;
    logic [WIDTH-1:0] dvd_reg,       dvd_next;
    logic             q_neg_reg,     q_neg_next;
    logic             r_neg_reg,     r_neg_next;
    logic             zero_div_reg,  zero_div_next;
    logic             ovf_reg,       ovf_next;
    logic [WIDTH-1:0] quotient_reg,  quotient_next;
    logic [WIDTH-1:0] remainder_reg, remainder_next;
    logic             dbz_out_reg,   dbz_out_next;
    logic             done_reg,      done_next;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             is_zero_div, is_ovf;
    logic [WIDTH-1:0] step_rem, step_quo;

    // Operand decode, used only when a start is accepted in IDLE.
    // Negating the most negative value yields itself, which is exactly its
    // magnitude read as an unsigned WIDTH-bit number.
    assign a_neg       = is_signed & dividend[WIDTH-1];
    assign b_neg       = is_signed & divisor[WIDTH-1];
    assign a_mag       = a_neg ? -dividend : dividend;
    assign b_mag       = b_neg ? -divisor  : divisor;
    assign is_zero_div = (divisor == '0);
    assign is_ovf      = is_signed && (dividend == MOST_NEG) && (divisor == '1);

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem     (rem_reg),
        .quo     (quo_reg),
        .divisor (dvs_reg),
        .rem_next(step_rem),
        .quo_next(step_quo)
    );

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        rem_next       = rem_reg;
        quo_next       = quo_reg;
        dvs_next       = dvs_reg;
        dvd_next       = dvd_reg;
        q_neg_next     = q_neg_reg;
        r_neg_next     = r_neg_reg;
        zero_div_next  = zero_div_reg;
        ovf_next       = ovf_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dbz_out_next   = dbz_out_reg;
        done_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    rem_next      = '0;
                    quo_next      = a_mag;
                    dvs_next      = b_mag;
                    dvd_next      = dividend;
                    q_neg_next    = a_neg ^ b_neg;
                    r_neg_next    = a_neg;
                    zero_div_next = is_zero_div;
                    ovf_next      = is_ovf;
                    cnt_next      = '0;
`ifdef DIVIDER_EARLY_OUT_EN
                    state_next    = (is_zero_div || is_ovf) ? FIX : CALC;
`else
                    state_next    = CALC;
`endif
                end
            end

            CALC: begin
                rem_next = step_rem;
                quo_next = step_quo;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_STEP) begin
                    state_next = FIX;
                end
            end

            FIX: begin
                if (zero_div_reg) begin
                    quotient_next  = '1;
                    remainder_next = dvd_reg;
                end else if (ovf_reg) begin
                    quotient_next  = MOST_NEG;
                    remainder_next = '0;
                end else begin
                    quotient_next  = q_neg_reg ? -quo_reg : quo_reg;
                    remainder_next = r_neg_reg ? -rem_reg : rem_reg;
                end
                dbz_out_next = zero_div_reg;
                done_next    = 1'b1;
                state_next   = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            dvs_reg       <= '0;
            dvd_reg       <= '0;
            q_neg_reg     <= 1'b0;
            r_neg_reg     <= 1'b0;
            zero_div_reg  <= 1'b0;
            ovf_reg       <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_out_reg   <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            rem_reg       <= rem_next;
            quo_reg       <= quo_next;
            dvs_reg       <= dvs_next;
            dvd_reg       <= dvd_next;
            q_neg_reg     <= q_neg_next;
            r_neg_reg     <= r_neg_next;
            zero_div_reg  <= zero_div_next;
            ovf_reg       <= ovf_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            dbz_out_reg   <= dbz_out_next;
            done_reg      <= done_next;
        end
    end

    // busy covers CALC and FIX; done is registered so it rises as busy falls.
    assign busy        = (state_reg != IDLE);
    assign done        = done_reg;
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_out_reg;

endmodule

// File: tb/tb_restoring_divider.sv
// -----------------------------------------------------------------------------
// tb_restoring_divider
// Table of directed vectors, hand-written handshake/reset sequences and a
// randomized sweep against a plain-arithmetic RISC-V division model.
// Honors DIVIDER_EARLY_OUT_EN for the expected latency of special cases.
// -----------------------------------------------------------------------------
module tb_restoring_divider;

    localparam int W        = 64;
    localparam int LAT_NORM = W + 1;
`ifdef DIVIDER_EARLY_OUT_EN
    localparam int LAT_SPEC = 1;
`else
    localparam int LAT_SPEC = W + 1;
`endif
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONES    = {W{1'b1}};

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks   = 0;
    int failures = 0;

    restoring_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // RISC-V reference: truncating division, with the two architectural fixups.
    task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        z = (b == 0);
        if (b == 0) begin
            q = ONES;
            r = a;
        end else if (s && a == MIN_NEG && b == ONES) begin
            q = a;
            r = '0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Starts an operation at the current time (posedge+1), waits for done and
    // checks results and latency. glitch_cyc >= 0 pulses a second start with
    // different operands at that cycle of the operation.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ez, input int elat, input int glitch_cyc);
        int cyc;
        bit seen;
        bit busy_drop;
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, " busy_after_start"}, W'(busy), W'(1));
        cyc       = 0;
        seen      = 1'b0;
        busy_drop = 1'b0;
        while (!seen && cyc < 200) begin
            if (cyc == glitch_cyc) begin
                start     = 1'b1;
                dividend  = 64'd1000;
                divisor   = 64'd3;
                is_signed = 1'b0;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
            if (done) seen = 1'b1;
            else if (!busy) busy_drop = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s timeout actual=no_done required=done_within_200", tag);
            return;
        end
        check({tag, " latency"},     W'(cyc),         W'(elat));
        check({tag, " busy_during"}, W'(busy_drop),   W'(0));
        check({tag, " busy_at_done"}, W'(busy),       W'(0));
        check({tag, " quotient"},    quotient,        eq);
        check({tag, " remainder"},   remainder,       er);
        check({tag, " div_by_zero"}, W'(div_by_zero), W'(ez));
        $display("txn %s a=%h b=%h s=%0d q=%h r=%h z=%0d lat=%0d",
                 tag, a, b, s, quotient, remainder, div_by_zero, cyc);
    endtask

    // Watches for a spurious done over n cycles; busy must stay low too.
    task automatic expect_quiet(input string tag, input int n);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) bad = 1'b1;
        end
        check({tag, " no_extra_done"}, W'(bad), W'(0));
    endtask

    initial begin
        logic [W-1:0] ra, rb, rq, rr;
        logic         rs, rz;
        int           rlat;

        vecs[0]  = '{64'd100,         64'd7,           1'b0, 64'd14,   64'd2,    1'b0, LAT_NORM};
        vecs[1]  = '{-64'd100,        64'd7,           1'b1, -64'd14,  -64'd2,   1'b0, LAT_NORM};
        vecs[2]  = '{64'd100,         -64'd7,          1'b1, -64'd14,  64'd2,    1'b0, LAT_NORM};
        vecs[3]  = '{-64'd100,        -64'd7,          1'b1, 64'd14,   -64'd2,   1'b0, LAT_NORM};
        vecs[4]  = '{64'h1234,        64'd0,           1'b0, ONES,     64'h1234, 1'b1, LAT_SPEC};
        vecs[5]  = '{64'h1234,        64'd0,           1'b1, ONES,     64'h1234, 1'b1, LAT_SPEC};
        vecs[6]  = '{MIN_NEG,         ONES,            1'b1, MIN_NEG,  64'd0,    1'b0, LAT_SPEC};
        vecs[7]  = '{MIN_NEG,         ONES,            1'b0, 64'd0,    MIN_NEG,  1'b0, LAT_NORM};
        vecs[8]  = '{ONES,            64'd1,           1'b0, ONES,     64'd0,    1'b0, LAT_NORM};
        vecs[9]  = '{64'd7,           64'd100,         1'b0, 64'd0,    64'd7,    1'b0, LAT_NORM};
        vecs[10] = '{MIN_NEG,         64'd1,           1'b1, MIN_NEG,  64'd0,    1'b0, LAT_NORM};
        vecs[11] = '{ONES,            64'd0,           1'b1, ONES,     ONES,     1'b1, LAT_SPEC};

        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset quotient",    quotient,        '0);
        check("reset remainder",   remainder,       '0);
        check("reset div_by_zero", W'(div_by_zero), W'(0));
        check("reset done",        W'(done),        W'(0));
        check("reset busy",        W'(busy),        W'(0));

        // Directed table
        for (int i = 0; i < 12; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
                  vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].lat, -1);
        end

        // Second start at cycle 10 is ignored, operands not re-sampled.
        do_op("glitch", 64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0, LAT_NORM, 10);
        expect_quiet("glitch", 70);

        // Start held during the done cycle: back-to-back operations.
        do_op("b2b_first",  64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0, LAT_NORM, -1);
        do_op("b2b_second", -64'd100, 64'd7, 1'b1, -64'd14, -64'd2, 1'b0, LAT_NORM, -1);

        // Reset at cycle 30 of an operation aborts it.
        dividend  = 64'd555;
        divisor   = 64'd5;
        is_signed = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midreset quotient",    quotient,        '0);
        check("midreset remainder",   remainder,       '0);
        check("midreset div_by_zero", W'(div_by_zero), W'(0));
        check("midreset done",        W'(done),        W'(0));
        check("midreset busy",        W'(busy),        W'(0));
        expect_quiet("midreset", 70);

        // Random sweep
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 5))
                0: begin ra = {$urandom, $urandom}; rb = 64'($urandom_range(1, 1000)); end
                1: begin ra = 64'($urandom); rb = 64'($urandom); end
                2: begin ra = {$urandom, $urandom}; rb = 64'd0; end
                3: begin ra = MIN_NEG; rb = ($urandom_range(0, 1) == 1) ? ONES : {$urandom, $urandom}; end
                4: begin ra = {$urandom, $urandom}; rb = -64'($urandom_range(1, 1000)); end
                default: begin ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; end
            endcase
            rs = 1'($urandom_range(0, 1));
            ref_div(ra, rb, rs, rq, rr, rz);
            rlat = (rb == 0 || (rs && ra == MIN_NEG && rb == ONES)) ? LAT_SPEC : LAT_NORM;
            do_op($sformatf("rnd%0d", i), ra, rb, rs, rq, rr, rz, rlat, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
